// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice.
package alu_pkg;

  // ALU control encoding seen on req_ctrl and by the alu datapath
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_t;

  // Bit positions inside the 4-bit {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Arbiter FSM: accept a request, evaluate it, then hold the response
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// Shared 32-bit datapath ALU: add, subtract, and, or with NZCV flags.
// Subtraction is a + ~b + 1, so C=1 means "no borrow".
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  ALUControl,
  output logic [31:0] Result,
  output logic [3:0]  ALUFlags
);

  logic [31:0] b_mux;
  logic [32:0] sum;
  logic        is_arith;

  assign b_mux    = ALUControl[0] ? ~b : b;
  assign sum      = {1'b0, a} + {1'b0, b_mux} + {32'd0, ALUControl[0]};
  assign is_arith = ~ALUControl[1];

  // Result select between adder and bitwise logic
  always_comb begin
    Result = sum[31:0];
    case (alu_op_t'(ALUControl))
      OP_ADD:  Result = sum[31:0];
      OP_SUB:  Result = sum[31:0];
      OP_AND:  Result = a & b;
      OP_OR:   Result = a | b;
      default: Result = sum[31:0];
    endcase
  end

  // Flags: carry/overflow only meaningful for add/sub, forced low for logic ops
  always_comb begin
    ALUFlags         = 4'b0000;
    ALUFlags[FLAG_N] = Result[31];
    ALUFlags[FLAG_Z] = (Result == 32'd0);
    ALUFlags[FLAG_C] = is_arith & sum[32];
    ALUFlags[FLAG_V] = is_arith & ~(ALUControl[0] ^ a[31] ^ b[31]) & (a[31] ^ sum[31]);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu among NREQ requesters.
// One op in flight at a time: IDLE (accept) -> EXEC (evaluate) -> RESP (hold
// until consumed). The requester that just won drops to lowest priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_ctrl,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_result,
  output logic [3:0]           rsp_flags,
  output logic                 busy,
  output logic [CNTW-1:0]      ops_done
);

  // First valid requester searching upward from last+1 with wrap.
  // The sum is kept one bit wider so the wrap works for non power-of-two NREQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  last);
    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] pick;
    logic           found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, last} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      cand = sum[IDW-1:0];
      if (!found && valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  arb_state_t       state_q, state_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  alu_op_t          op_ctrl_q, op_ctrl_d;
  logic [31:0]      op_a_q, op_a_d;
  logic [31:0]      op_b_q, op_b_d;
  logic [IDW-1:0]   op_id_q, op_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [31:0]      rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic [CNTW-1:0]  ops_done_q, ops_done_d;

  logic [1:0]       ctrl_arr [NREQ];
  logic [31:0]      a_arr    [NREQ];
  logic [31:0]      b_arr    [NREQ];
  logic             grant_en;
  logic [IDW-1:0]   grant_id;
  logic [31:0]      alu_result;
  logic [3:0]       alu_flags;

  assign grant_en = (state_q == IDLE) && (|req_valid);
  assign grant_id = rr_pick(req_valid, last_grant_q);

  // Per-requester operand slices and one-hot ready decode
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign ctrl_arr[gi]  = req_ctrl[2*gi +: 2];
      assign a_arr[gi]     = req_a[32*gi +: 32];
      assign b_arr[gi]     = req_b[32*gi +: 32];
      assign req_ready[gi] = grant_en && (grant_id == IDW'(gi));
    end
  endgenerate

  alu u_alu (
    .a          (op_a_q),
    .b          (op_b_q),
    .ALUControl (op_ctrl_q),
    .Result     (alu_result),
    .ALUFlags   (alu_flags)
  );

  // Next-state: capture winner in IDLE, latch ALU output in EXEC, wait in RESP
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_ctrl_d    = op_ctrl_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_id_d      = op_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    ops_done_d   = ops_done_q;
    case (state_q)
      IDLE: begin
        if (grant_en) begin
          op_ctrl_d    = alu_op_t'(ctrl_arr[grant_id]);
          op_a_d       = a_arr[grant_id];
          op_b_d       = b_arr[grant_id];
          op_id_d      = grant_id;
          last_grant_d = grant_id;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_flags_d  = alu_flags;
        rsp_id_d     = op_id_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ops_done_d  = ops_done_q + CNTW'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any in-flight op
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      op_ctrl_q    <= OP_ADD;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_id_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_ctrl_q    <= op_ctrl_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_id_q      <= op_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign ops_done   = ops_done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one alu instance between NREQ requesters, e.g. the integer pipe, address-gen unit and a debug port.
- Round-robin arbitration with a valid/ready request handshake.
- Operands are registered and the ALU evaluates one op at a time; the result and NZCV flags return on a single tagged response channel.
- Sits between the decode/issue logic and the shared datapath ALU.

Parameters:
NREQ, 2, number of requesters (2..8)
IDW, $clog2(NREQ) (min 1), width of requester id tag
CNTW, 16, width of completed-op counter

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept (one-hot or zero)
req_ctrl  input  2*NREQ  ALU control per requester; slice i = [2i+1:2i]
req_a  input  32*NREQ  operand a per requester; slice i = [32i+31:32i]
req_b  input  32*NREQ  operand b per requester
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed
rsp_id  output  IDW  requester index that owns the response
rsp_result  output  32  ALU result
rsp_flags  output  4  {N,Z,C,V}
busy  output  1  high whenever state != IDLE
ops_done  output  CNTW  count of completed response handshakes, wraps

Behaviour:
- Reset, asynchronous, reset_n=0:
  - state=IDLE, last_grant=NREQ-1 so requester 0 wins first.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, ops_done=0.
  - req_ready=0, busy=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from (last_grant+1) mod NREQ upward, with wrap.
  - req_ready[grant]=1 combinationally in the same cycle. All other ready bits are 0.
  - On the clock edge: capture ctrl/a/b of the winner into op registers, capture the id, set last_grant=grant, go to EXEC.
  - No req_valid: stay in IDLE, all ready bits 0.
- EXEC:
  - alu sees the registered ctrl/a/b.
  - On the edge: rsp_result<=Result, rsp_flags<=ALUFlags, rsp_id<=captured id, rsp_valid<=1, go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
  - When rsp_ready=1: on the edge rsp_valid<=0, ops_done<=ops_done+1 (mod 2^CNTW), go to IDLE.
  - rsp_result/flags/id retain their last values after the handshake.
- Timing:
  - Latency from accept edge to rsp_valid: 2 cycles.
  - Minimum issue interval: 3 cycles, i.e. one op per IDLE->EXEC->RESP loop.
- req_ready is 0 in EXEC and RESP. Requests arriving there wait; their valid bits are sampled again in IDLE.
- Protocol rule: a requester holds req_valid and its operands stable until it sees req_ready. Deassertion before ready is a protocol violation; the bench asserts on it.
- Fairness: a requester that just won has lowest priority next round. With all NREQ valid continuously, grant order is 0,1,..,NREQ-1,0.
- Flags follow alu semantics:
  - ADD/SUB: C = adder carry-out (SUB: 1 = no borrow); V = signed overflow.
  - AND/OR: C=0, V=0.
  - N = result[31]; Z = (result==0).
- All four ctrl codes are legal; no illegal-op path.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded, no response is issued, and the requester must reissue.
- rsp_ready high while rsp_valid=0 is ignored.

Decomposition:
- Package alu_pkg:
  - alu_op_t enum: OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11.
  - Flag index constants: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - arb_state_t enum: IDLE, EXEC, RESP.
- Sub-module: instantiate the existing alu unchanged.
- Round-robin selection is a function inside alu_arbiter; no separate module.

Test Plan:
- Req0 only, ADD a=0xFFFFFFFF b=0x00000001 -> rsp 2 cycles after accept: rsp_id=0, result=0x00000000, flags=4'b0110; ops_done=1 after handshake.
- Req1 only, ADD a=0x7FFFFFFF b=0x00000001 -> result=0x80000000, flags=4'b1001, rsp_id=1.
- Req0 SUB 5-5 and req1 SUB 3-5 both valid from reset:
  - Req0 is granted first: result=0, flags=4'b0110.
  - Req1 is granted next: result=0xFFFFFFFE, flags=4'b1000.
  - req_ready is never two-hot.
- Both requesters valid for 6 back-to-back ops, rsp_ready tied high:
  - Grant order is 0,1,0,1,0,1 with a 3-cycle issue interval.
  - Ops AND 0x0000F0F0&0x00000FF0 -> 0x000000F0, flags 0000; OR 0x80000000|0x1 -> 0x80000001, flags 1000.
- rsp_ready held low for 5 cycles in RESP -> rsp_* stable; busy=1; req_ready=0 despite pending req_valid; ops_done unchanged until the handshake.
- reset_n pulsed low during EXEC -> rsp_valid stays 0, state=IDLE, last_grant reset so requester 0 wins next, ops_done=0.
